// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// Latency: none (wires only).
// Backpressure: none; start is only honoured while the subtractor is idle.
// Optional OVERFLOW_EN adds the ovf result bit.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
`ifdef OVERFLOW_EN
  logic             ovf;
`endif

  // Requester side: drives operands, watches status/results.
  modport master (
    output start, a, b, b_in,
`ifdef OVERFLOW_EN
    input  ovf,
`endif
    input  busy, done, diff, b_out
  );

  // Subtractor side.
  modport slave (
    input  start, a, b, b_in,
`ifdef OVERFLOW_EN
    output ovf,
`endif
    output busy, done, diff, b_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - b_in, one bit per clock, LSB first.
// Latency: start accepted at edge N, done pulses in the cycle after edge N+WIDTH; one result per WIDTH+2 cycles.
// Backpressure: start is ignored while busy or done; no queuing. Macro OVERFLOW_EN adds signed overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
`ifdef OVERFLOW_EN
  logic             r_ovf;
`endif

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_next;

  // One full-subtractor cell on the current LSBs of the operand shift registers.
  assign w_a_bit    = r_a[0];
  assign w_b_bit    = r_b[0];
  assign w_d        = w_a_bit ^ w_b_bit ^ r_br;
  assign w_br_next  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  // Control FSM plus datapath; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
`ifdef OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_br    <= bus.b_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            r_diff  <= w_res_next;
            r_bout  <= w_br_next;
`ifdef OVERFLOW_EN
            // On the last bit the operand LSBs are the original sign bits.
            r_ovf   <= (w_a_bit ^ w_b_bit) & (w_d ^ w_a_bit);
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.diff  = r_diff;
  assign bus.b_out = r_bout;
`ifdef OVERFLOW_EN
  assign bus.ovf   = r_ovf;
`endif

endmodule
